motor_pwm_driver: RTL and testbench



---
 rtl/motor_pwm_driver.sv | 187 ++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// Per-wheel H-bridge driver: synchronised motor command in, direction pins plus PWM out,
// with soft-start/soft-stop ramping, reversal dead-time and proximity emergency brake.
module motor_pwm_driver #(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_SLOW   = 500,
    parameter int DUTY_FAST   = 1000,
    parameter int RAMP_STEP   = 50,
    parameter int RAMP_DIV    = 5000,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] motor_cmd,
    input  logic       prox_in,
    output logic       in_a,
    output logic       in_b,
    output logic       pwm_out,
    output logic       busy,
    output logic       blocked
);

    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DW = $clog2(PWM_PERIOD + RAMP_STEP + 1);
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int CW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [DW-1:0] STEP      = DW'(RAMP_STEP);
    localparam logic [DW-1:0] TGT_SLOW  = DW'(DUTY_SLOW);
    localparam logic [DW-1:0] TGT_FAST  = DW'(DUTY_FAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RAMP_DOWN,
        S_DEAD,
        S_BRAKE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cmd_s1_q, cmd_s2_q;
    logic          prox_s1_q, prox_s2_q;
    logic          dir_q, dir_d;
    logic [DW-1:0] ramp_q, ramp_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [CW-1:0] dead_cnt_q, dead_cnt_d;
    logic          in_a_q, in_a_d, in_b_q, in_b_d;
    logic          pwm_q, pwm_d, busy_q, busy_d, blocked_q, blocked_d;

    logic          en, dir, fast, prox, fwd_brake, ramping, tick, clear;
    logic [DW-1:0] target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_s1_q   <= '0;
            cmd_s2_q   <= '0;
            prox_s1_q  <= 1'b0;
            prox_s2_q  <= 1'b0;
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            ramp_q     <= '0;
            duty_q     <= '0;
            pwm_cnt_q  <= '0;
            ramp_cnt_q <= '0;
            dead_cnt_q <= '0;
            in_a_q     <= 1'b0;
            in_b_q     <= 1'b0;
            pwm_q      <= 1'b0;
            busy_q     <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            cmd_s1_q   <= motor_cmd;
            cmd_s2_q   <= cmd_s1_q;
            prox_s1_q  <= prox_in;
            prox_s2_q  <= prox_s1_q;
            state_q    <= state_d;
            dir_q      <= dir_d;
            ramp_q     <= ramp_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
            pwm_q      <= pwm_d;
            busy_q     <= busy_d;
            blocked_q  <= blocked_d;
        end
    end

    always_comb begin
        en        = cmd_s2_q[0];
        dir       = cmd_s2_q[1];
        fast      = cmd_s2_q[2];
        prox      = prox_s2_q;
        fwd_brake = prox && dir_q;
        state_d   = state_q;
        dir_d     = dir_q;

        // Brake is checked first so it wins over a same-cycle disable or reversal.
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                    dir_d   = dir;
                end
            end
            S_RUN: begin
                if (fwd_brake)                state_d = S_BRAKE;
                else if (!en || dir != dir_q) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (fwd_brake)                         state_d = S_BRAKE;
                else if (ramp_q == '0 && duty_q == '0) state_d = S_DEAD;
            end
            S_DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    if (en) begin
                        state_d = S_RUN;
                        dir_d   = dir;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BRAKE: begin
                if (!prox || !(en && dir)) state_d = S_DEAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ramping    = (state_q == S_RUN) || (state_q == S_RAMP_DOWN);
        tick       = ramping && (ramp_cnt_q == RAMP_LAST);
        ramp_cnt_d = (ramping && !tick) ? ramp_cnt_q + 1'b1 : '0;
        target     = (state_q == S_RUN) ? (fast ? TGT_FAST : TGT_SLOW) : '0;
        clear      = !ramping || (state_d == S_BRAKE);

        ramp_d = ramp_q;
        if (tick) begin
            if (ramp_q < target)
                ramp_d = (target - ramp_q > STEP) ? ramp_q + STEP : target;
            else if (ramp_q > target)
                ramp_d = (ramp_q - target > STEP) ? ramp_q - STEP : target;
        end

        // Duty only changes at the period boundary, taking the post-tick ramp value.
        duty_d    = (pwm_cnt_q == PWM_LAST) ? ramp_d : duty_q;
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        if (clear) begin
            ramp_d = '0;
            duty_d = '0;
        end

        dead_cnt_d = (state_q == S_DEAD && dead_cnt_q != DEAD_LAST) ? dead_cnt_q + 1'b1 : '0;

        in_a_d = 1'b0;
        in_b_d = 1'b0;
        pwm_d  = 1'b0;
        case (state_d)
            S_RUN, S_RAMP_DOWN: begin
                in_a_d = dir_d;
                in_b_d = !dir_d;
                pwm_d  = DW'(pwm_cnt_q) < duty_q;
            end
            S_BRAKE: begin
                in_a_d = 1'b1;
                in_b_d = 1'b1;
            end
            default: ;
        endcase
        busy_d    = (state_d != S_IDLE);
        blocked_d = (state_d == S_BRAKE);
    end

    assign in_a    = in_a_q;
    assign in_b    = in_b_q;
    assign pwm_out = pwm_q;
    assign busy    = busy_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with short timing parameters; all
// expectations are hand-computed cycle offsets from the state-entry edge.
module tb_motor_pwm_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] motor_cmd;
    logic       prox_in;
    logic       in_a, in_b, pwm_out, busy, blocked;

    int n_tests = 0;
    int n_fail  = 0;

    motor_pwm_driver #(
        .PWM_PERIOD (10),
        .DUTY_SLOW  (4),
        .DUTY_FAST  (10),
        .RAMP_STEP  (2),
        .RAMP_DIV   (20),
        .DEAD_CYCLES(30)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .motor_cmd(motor_cmd),
        .prox_in  (prox_in),
        .in_a     (in_a),
        .in_b     (in_b),
        .pwm_out  (pwm_out),
        .busy     (busy),
        .blocked  (blocked)
    );

    always #5 clk = ~clk;

    // One rising edge, then land on the falling edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_pwm(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        motor_cmd = 3'b000;
        prox_in   = 1'b0;
        step(3);
        n_tests++;
        if ({in_a, in_b, pwm_out, busy, blocked} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {in_a, in_b, pwm_out, busy, blocked});
        end
        reset_n = 1'b1;
        step(5);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_slow_fwd;
        int c;
        motor_cmd = 3'b011;
        step(2);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: busy after 2 cycles got %b expected 0", busy);
        end
        step(1);
        n_tests++;
        if ({in_a, in_b, busy, blocked} !== 4'b1010) begin
            n_fail++;
            $display("FAIL run_fwd_pins: a/b/busy/blk got %b expected 1010", {in_a, in_b, busy, blocked});
        end
        count_pwm(10, c);
        n_tests++;
        if (c !== 0) begin
            n_fail++;
            $display("FAIL slow_duty0: high count got %0d expected 0", c);
        end
        step(20);
        count_pwm(10, c);
        n_tests++;
        if (c !== 2) begin
            n_fail++;
            $display("FAIL slow_duty2: high count got %0d expected 2", c);
        end
        step(20);
        count_pwm(10, c);
        n_tests++;
        if (c !== 4) begin
            n_fail++;
            $display("FAIL slow_duty4: high count got %0d expected 4", c);
        end
    endtask

    task automatic test_fast;
        int c;
        motor_cmd = 3'b111;
        step(20);
        count_pwm(10, c);
        n_tests++;
        if (c !== 6) begin
            n_fail++;
            $display("FAIL fast_duty6: high count got %0d expected 6", c);
        end
        step(10);
        count_pwm(10, c);
        n_tests++;
        if (c !== 8) begin
            n_fail++;
            $display("FAIL fast_duty8: high count got %0d expected 8", c);
        end
        step(10);
        count_pwm(20, c);
        n_tests++;
        if (c !== 20) begin
            n_fail++;
            $display("FAIL fast_duty10: high count got %0d expected 20", c);
        end
        n_tests++;
        if ({in_a, in_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL fast_pins: a/b got %b expected 10", {in_a, in_b});
        end
    endtask

    task automatic test_reverse;
        int c;
        bit ok;
        motor_cmd = 3'b011;
        step(60);
        count_pwm(10, c);
        n_tests++;
        if (c !== 4) begin
            n_fail++;
            $display("FAIL back_to_slow: high count got %0d expected 4", c);
        end
        motor_cmd = 3'b001;
        ok = 1'b1;
        repeat (40) begin
            step(1);
            if ({in_a, in_b} !== 2'b10) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rampdown_pins: a/b got %b expected 10 throughout", {in_a, in_b});
        end
        for (int i = 0; i < 20 && in_a !== 1'b0; i++) step(1);
        n_tests++;
        if ({in_a, in_b, pwm_out, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL dead_entry: a/b/pwm/busy got %b expected 0001", {in_a, in_b, pwm_out, busy});
        end
        ok = 1'b1;
        repeat (29) begin
            step(1);
            if ({in_a, in_b, pwm_out} !== 3'b000) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dead_coast: a/b/pwm got %b expected 000 for 30 cycles", {in_a, in_b, pwm_out});
        end
        step(1);
        n_tests++;
        if ({in_a, in_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL reverse_pins: a/b got %b expected 01", {in_a, in_b});
        end
        count_pwm(10, c);
        n_tests++;
        if (c !== 0) begin
            n_fail++;
            $display("FAIL rev_duty0: high count got %0d expected 0", c);
        end
        step(20);
        count_pwm(10, c);
        n_tests++;
        if (c !== 2) begin
            n_fail++;
            $display("FAIL rev_duty2: high count got %0d expected 2", c);
        end
    endtask

    task automatic test_reverse_prox;
        int c;
        prox_in = 1'b1;
        step(10);
        count_pwm(10, c);
        n_tests++;
        if (c !== 4) begin
            n_fail++;
            $display("FAIL rev_prox_pwm: high count got %0d expected 4", c);
        end
        n_tests++;
        if ({in_a, in_b, blocked} !== 3'b010) begin
            n_fail++;
            $display("FAIL rev_prox_pins: a/b/blk got %b expected 010", {in_a, in_b, blocked});
        end
        prox_in = 1'b0;
    endtask

    task automatic test_brake;
        int c;
        bit ok;
        motor_cmd = 3'b011;
        for (int i = 0; i < 200 && {in_a, in_b} !== 2'b10; i++) step(1);
        n_tests++;
        if ({in_a, in_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL refwd_timeout: a/b got %b expected 10", {in_a, in_b});
        end
        step(40);
        prox_in = 1'b1;
        step(2);
        n_tests++;
        if (blocked !== 1'b0) begin
            n_fail++;
            $display("FAIL brake_latency: blocked after 2 cycles got %b expected 0", blocked);
        end
        step(1);
        n_tests++;
        if ({in_a, in_b, pwm_out, busy, blocked} !== 5'b11011) begin
            n_fail++;
            $display("FAIL brake_pins: a/b/pwm/busy/blk got %b expected 11011", {in_a, in_b, pwm_out, busy, blocked});
        end
        ok = 1'b1;
        repeat (10) begin
            step(1);
            if ({in_a, in_b, pwm_out} !== 3'b110) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL brake_hold: a/b/pwm got %b expected 110", {in_a, in_b, pwm_out});
        end
        prox_in = 1'b0;
        step(3);
        n_tests++;
        if ({in_a, in_b, blocked, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL brake_exit: a/b/blk/busy got %b expected 0001", {in_a, in_b, blocked, busy});
        end
        step(29);
        n_tests++;
        if ({in_a, in_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL brake_dead_len: a/b got %b expected 00", {in_a, in_b});
        end
        step(1);
        n_tests++;
        if ({in_a, in_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL brake_resume: a/b got %b expected 10", {in_a, in_b});
        end
        count_pwm(10, c);
        n_tests++;
        if (c !== 0) begin
            n_fail++;
            $display("FAIL brake_duty_cleared: high count got %0d expected 0", c);
        end
        step(20);
        count_pwm(10, c);
        n_tests++;
        if (c !== 2) begin
            n_fail++;
            $display("FAIL brake_reramp: high count got %0d expected 2", c);
        end
    endtask

    task automatic test_simultaneous;
        prox_in   = 1'b1;
        motor_cmd = 3'b000;
        step(3);
        n_tests++;
        if ({in_a, in_b, blocked} !== 3'b111) begin
            n_fail++;
            $display("FAIL brake_priority: a/b/blk got %b expected 111", {in_a, in_b, blocked});
        end
        step(37);
        n_tests++;
        if ({in_a, in_b, busy, blocked} !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_idle: a/b/busy/blk got %b expected 0000", {in_a, in_b, busy, blocked});
        end
        prox_in = 1'b0;
    endtask

    task automatic test_reset_mid;
        motor_cmd = 3'b111;
        step(68);
        n_tests++;
        if ({in_a, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_run: a/busy got %b expected 11", {in_a, busy});
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({in_a, in_b, pwm_out, busy, blocked} !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 00000", {in_a, in_b, pwm_out, busy, blocked});
        end
        step(1);
        motor_cmd = 3'b000;
        reset_n   = 1'b1;
        step(10);
        n_tests++;
        if ({in_a, in_b, pwm_out, busy, blocked} !== 5'b00000) begin
            n_fail++;
            $display("FAIL idle_after_mid_reset: got %b expected 00000", {in_a, in_b, pwm_out, busy, blocked});
        end
    endtask

    initial begin
        test_reset();
        test_slow_fwd();
        test_fast();
        test_reverse();
        test_reverse_prox();
        test_brake();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
